// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arb_pkg
// Purpose  : Shared constants and types for the two-requester ALU arbiter:
//            FSM state encoding, ALU opcode values and the ALU width.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package alu_arb_pkg;

  localparam int ALU_W = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_EXEC = S_EXEC,
    ST_RESP = S_RESP
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_alu
// Purpose  : The shared two-operation ALU. Purely combinational, modulo
//            2^WIDTH arithmetic with no carry or overflow indication.
// Ports    : A, B   operands
//            Op     OP_ADD -> S = A + B, OP_SUB -> S = A - B
//            S      result
// Revision : 1.0  initial release
// ============================================================================
module alu_arbiter_alu
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Op,
  output logic [WIDTH-1:0] S
);

  // Result is truncated to WIDTH bits, so wrap-around is silent.
  always_comb begin
    S = (Op == OP_ADD) ? (A + B) : (A - B);
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one ALU between two valid/ready requesters. Grants one
//            request at a time (round-robin or fixed priority), registers the
//            operands into the ALU, captures the result and returns it with
//            the id of the requester that issued it. One op per 3 cycles max.
// Ports    : clk, rst_n                clock, async active-low reset
//            req{0,1}_valid/_ready     request handshake (ready is comb.)
//            req{0,1}_a/_b/_op         operands and opcode (1 = add, 0 = sub)
//            rsp_valid/rsp_ready       response handshake
//            rsp_data, rsp_id          ALU result and originating requester
//            busy                      arbiter not idle
//            grant_cnt0/1              saturating grant counters (stats only)
// Config   : define ALU_ARB_STATS_EN to add the grant_cnt0/grant_cnt1 ports.
// Revision : 1.0  initial release
// ============================================================================
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int FAIR  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1,
`endif
  output logic             busy
);

  arb_state_t       r_state;
  arb_state_t       w_next_state;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_op_op;
  logic             r_op_id;
  logic             w_pick1;
  logic             w_grant;
  logic [WIDTH-1:0] w_alu_s;

  // Requester 1 wins when it is the only one asking, or, in round-robin mode,
  // when requester 0 had the most recent grant.
  assign w_pick1 = req1_valid &&
                   (!req0_valid || ((FAIR != 0) && !r_last_grant));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          w_grant      = 1'b1;
          req0_ready   = !w_pick1;
          req1_ready   = w_pick1;
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_next_state = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Derived straight from the state so an asynchronous reset clears them
  // without waiting for a clock edge.
  assign rsp_valid = (r_state == ST_RESP);
  assign busy      = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_op      <= 1'b0;
      r_op_id      <= 1'b0;
      r_last_grant <= 1'b1;
      rsp_data     <= '0;
      rsp_id       <= 1'b0;
    end else begin
      if (w_grant) begin
        r_op_a       <= w_pick1 ? req1_a  : req0_a;
        r_op_b       <= w_pick1 ? req1_b  : req0_b;
        r_op_op      <= w_pick1 ? req1_op : req0_op;
        r_op_id      <= w_pick1;
        r_last_grant <= w_pick1;
      end
      // Result and id are only written on leaving EXEC, so they stay stable
      // for the whole RESP phase regardless of backpressure.
      if (r_state == ST_EXEC) begin
        rsp_data <= w_alu_s;
        rsp_id   <= r_op_id;
      end
    end
  end

  alu_arbiter_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .A  (r_op_a),
    .B  (r_op_b),
    .Op (r_op_op),
    .S  (w_alu_s)
  );

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (w_grant) begin
      if (!w_pick1 && (grant_cnt0 != 16'hFFFF)) begin
        grant_cnt0 <= grant_cnt0 + 16'd1;
      end
      if (w_pick1 && (grant_cnt1 != 16'hFFFF)) begin
        grant_cnt1 <= grant_cnt1 + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed self-checking bench for alu_arbiter. One round-robin
//            instance (dut) and one fixed-priority instance (dut_fp) share
//            clock and reset.
// Config   : honours ALU_ARB_STATS_EN (grant counter ports).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // round-robin instance
  logic        v0 = 0, v1 = 0, op0 = 0, op1 = 0, rdy = 1;
  logic [15:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [15:0] rsp_data;
  logic [15:0] cnt0, cnt1;

  // fixed-priority instance
  logic        fv0 = 0, fv1 = 0, fop0 = 0, fop1 = 0, frdy = 1;
  logic [15:0] fa0 = 0, fb0 = 0, fa1 = 0, fb1 = 0;
  logic        f_ready0, f_ready1, f_valid, f_id, f_busy;
  logic [15:0] f_data;
  logic [15:0] fcnt0, fcnt1;

  int n_total = 0;
  int n_bad   = 0;

  alu_arbiter #(.WIDTH(16), .FAIR(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(req0_ready), .req0_a(a0), .req0_b(b0), .req0_op(op0),
    .req1_valid(v1), .req1_ready(req1_ready), .req1_a(a1), .req1_b(b1), .req1_op(op1),
    .rsp_valid(rsp_valid), .rsp_ready(rdy), .rsp_data(rsp_data), .rsp_id(rsp_id),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt0(cnt0), .grant_cnt1(cnt1),
`endif
    .busy(busy)
  );

  alu_arbiter #(.WIDTH(16), .FAIR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(fv0), .req0_ready(f_ready0), .req0_a(fa0), .req0_b(fb0), .req0_op(fop0),
    .req1_valid(fv1), .req1_ready(f_ready1), .req1_a(fa1), .req1_b(fb1), .req1_op(fop1),
    .rsp_valid(f_valid), .rsp_ready(frdy), .rsp_data(f_data), .rsp_id(f_id),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt0(fcnt0), .grant_cnt1(fcnt1),
`endif
    .busy(f_busy)
  );

`ifndef ALU_ARB_STATS_EN
  assign cnt0  = '0;
  assign cnt1  = '0;
  assign fcnt0 = '0;
  assign fcnt1 = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated request on the round-robin instance with rsp_ready high.
  task automatic single_op(input logic who, input logic [15:0] a, input logic [15:0] b,
                           input logic op, input logic [15:0] exp);
    if (!who) begin a0 = a; b0 = b; op0 = op; v0 = 1; end
    else      begin a1 = a; b1 = b; op1 = op; v1 = 1; end
    #1;
    chk("accept_ready0", req0_ready, !who);
    chk("accept_ready1", req1_ready, who);
    tick();
    v0 = 0; v1 = 0;
    #1;
    chk("exec_busy", busy, 1);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_ready0", req0_ready, 0);
    tick();
    chk("resp_valid", rsp_valid, 1);
    chk("resp_data", rsp_data, exp);
    chk("resp_id", rsp_id, who);
    tick();
    chk("back_idle_busy", busy, 0);
    chk("back_idle_valid", rsp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_cnt0", cnt0, 0);
    rst_n = 1;
    tick();

    // single add and subtract wrap
    single_op(1'b0, 16'd10, 16'd12, 1'b1, 16'd22);
    single_op(1'b1, 16'd0, 16'd1, 1'b0, 16'hFFFF);

    // round-robin contention: last grant was 1, so order is 0,1,0,1
    a0 = 16'd100; b0 = 16'd1;  op0 = 1'b1;
    a1 = 16'd50;  b1 = 16'd20; op1 = 1'b0;
    v0 = 1; v1 = 1;
    for (int i = 0; i < 4; i++) begin
      logic e;
      e = (i % 2) == 1;
      #1;
      chk("rr_ready0", req0_ready, !e);
      chk("rr_ready1", req1_ready, e);
      tick();
      chk("rr_exec_busy", busy, 1);
      tick();
      chk("rr_valid", rsp_valid, 1);
      chk("rr_id", rsp_id, e);
      chk("rr_data", rsp_data, e ? 16'd30 : 16'd101);
      tick();
    end
    v0 = 0; v1 = 0;
    tick();

    // backpressure: requester 1 alone, add wraps to 1
    rdy = 0;
    a1 = 16'h8000; b1 = 16'h8001; op1 = 1'b1; v1 = 1;
    #1;
    chk("bp_accept1", req1_ready, 1);
    tick();
    v0 = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 16'h0001);
      chk("bp_id", rsp_id, 1);
      chk("bp_busy", busy, 1);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      tick();
    end
    v0 = 0; v1 = 0; rdy = 1;
    tick();
    chk("bp_release_busy", busy, 0);
    chk("bp_release_valid", rsp_valid, 0);

    // reset while in EXEC
    a0 = 16'd7; b0 = 16'd3; op0 = 1'b0; v0 = 1;
    #1;
    tick();
    v0 = 0;
    #1;
    chk("rx_exec_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("rx_valid", rsp_valid, 0);
    chk("rx_busy", busy, 0);
    chk("rx_data", rsp_data, 0);
    chk("rx_id", rsp_id, 0);
    tick();
    tick();
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rx_no_rsp", rsp_valid, 0);
      chk("rx_idle", busy, 0);
    end

    // fixed priority: requester 0 always wins
    fa0 = 16'hFFFF; fb0 = 16'd1; fop0 = 1'b1;
    fa1 = 16'd3;    fb1 = 16'd4; fop1 = 1'b1;
    fv0 = 1; fv1 = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fp_ready0", f_ready0, 1);
      chk("fp_ready1", f_ready1, 0);
      tick();
      tick();
      chk("fp_valid", f_valid, 1);
      chk("fp_id", f_id, 0);
      chk("fp_data", f_data, 16'h0000);
      tick();
    end
    fv0 = 0;
`ifdef ALU_ARB_STATS_EN
    chk("fp_cnt0", fcnt0, 4);
    chk("fp_cnt1", fcnt1, 0);
`endif
    #1;
    chk("fp_ready1_alone", f_ready1, 1);
    tick();
    fv1 = 0;
    tick();
    chk("fp_alone_id", f_id, 1);
    chk("fp_alone_data", f_data, 16'd7);
    tick();
    chk("fp_idle", f_busy, 0);
`ifdef ALU_ARB_STATS_EN
    chk("fp_cnt1_after", fcnt1, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
